// File: rtl/clk_enable_prog_if.sv
// rtl/clk_enable_prog_if.sv - control/status bundle for the programmable clock-enable generator
interface clk_enable_prog_if #(
  parameter int CNT_W   = 4,
  parameter int BURST_W = 8
);
  logic               iStart;
  logic               iStop;
  logic               iMode;
  logic [CNT_W-1:0]   iDiv;
  logic               iDivWr;
  logic [BURST_W-1:0] iBurstLen;
  logic               oEnable;
  logic               oBusy;
  logic               oDone;
  logic [CNT_W-1:0]   oCnt;

  modport master (
    output iStart, iStop, iMode, iDiv, iDivWr, iBurstLen,
    input  oEnable, oBusy, oDone, oCnt
  );

  modport slave (
    input  iStart, iStop, iMode, iDiv, iDivWr, iBurstLen,
    output oEnable, oBusy, oDone, oCnt
  );
endinterface

// File: rtl/clk_enable_prog.sv
// rtl/clk_enable_prog.sv - programmable one-cycle enable strobe, continuous or counted burst
module clk_enable_prog #(
  parameter int CNT_W   = 4,
  parameter int BURST_W = 8,
  parameter int DEF_DIV = 4
) (
  input  logic             iClk,
  input  logic             iRst,
  clk_enable_prog_if.slave bus
);

  localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [CNT_W-1:0]   rCnt;
  logic [CNT_W-1:0]   rDivSh;
  logic [CNT_W-1:0]   rDivAct;
  logic [BURST_W-1:0] rLeft;
  logic               rMode;

  logic [CNT_W-1:0]   w_cnt_nx;
  logic [CNT_W-1:0]   w_div_act_nx;
  logic [BURST_W-1:0] w_left_nx;
  logic               w_mode_nx;
  logic [CNT_W-1:0]   w_div_sel;
  logic               w_wrap;

  // A write landing on a wrap or start bypasses the shadow so it takes effect at once.
  assign w_div_sel = bus.iDivWr ? bus.iDiv : rDivSh;
  assign w_wrap    = (rCnt == rDivAct);

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = rCnt;
    w_div_act_nx = rDivAct;
    w_left_nx    = rLeft;
    w_mode_nx    = rMode;
    case (r_state)
      S_IDLE: begin
        if (bus.iStart && !bus.iStop) begin
          w_cnt_nx     = '0;
          w_div_act_nx = w_div_sel;
          w_mode_nx    = bus.iMode;
          w_left_nx    = bus.iBurstLen;
          w_state_nx   = (bus.iMode && (bus.iBurstLen == '0)) ? S_FINISH : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.iStop) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else if (w_wrap) begin
          w_cnt_nx     = '0;
          w_div_act_nx = w_div_sel;
          if (rMode) begin
            w_left_nx = rLeft - BURST_W'(1);
            if (rLeft == BURST_W'(1)) begin
              w_state_nx = S_FINISH;
            end
          end
        end else begin
          w_cnt_nx = rCnt + CNT_W'(1);
        end
      end
      S_FINISH: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= S_IDLE;
      rCnt    <= '0;
      rDivSh  <= DEF_DIV_C;
      rDivAct <= DEF_DIV_C;
      rLeft   <= '0;
      rMode   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      rCnt    <= w_cnt_nx;
      rDivAct <= w_div_act_nx;
      rLeft   <= w_left_nx;
      rMode   <= w_mode_nx;
      if (bus.iDivWr) begin
        rDivSh <= bus.iDiv;
      end
    end
  end

  assign bus.oEnable = (r_state == S_RUN) && w_wrap;
  assign bus.oBusy   = (r_state == S_RUN);
  assign bus.oDone   = (r_state == S_FINISH);
  assign bus.oCnt    = rCnt;

endmodule
